matrix_stream_loader: RTL and testbench
=======================================

# matrix_stream_loader

Upstream feeder for the 4x4 parallel matrix-multiply engine. It accepts matrix elements one (A, B) pair per handshake in column-major order and packs every two consecutive rows into one beat in the engine's load format, {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}. A 2-entry beat buffer lets the engine apply backpressure. After the last beat it pulses `load_done` so the compute stage can be started.

## Interface
- `WIDTH`, 8: element width in bits.
- `NUM_ELEMENTS`, 4: elements per output beat. Must be 4; elaboration error otherwise.
- `MATRIX_WIDTH`, 4: matrix dimension. Must be even; elaboration error otherwise.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a new matrix load; sampled only in IDLE.
- `in_valid`  in  1  `in_a`/`in_b` valid.
- `in_a`  in  WIDTH  element A[r][c].
- `in_b`  in  WIDTH  element B[r][c].
- `in_ready`  out  1  pair accepted on a cycle where `in_valid && in_ready`.
- `sink_ready`  in  1  engine can take a beat.
- `rdata`  out  NUM_ELEMENTS*WIDTH  packed beat; A[r] in the MSBs.
- `read_en`  out  1  one-cycle strobe: `rdata` valid.
- `busy`  out  1  state != IDLE.
- `load_done`  out  1  one-cycle pulse, coincident with the final `read_en`.

## Operation
- Constants:
  - PAIRS = MATRIX_WIDTH². Default 16.
  - BEATS = PAIRS/2. Default 8.
- Pair order: index p = c·MATRIX_WIDTH + r, with r fastest.
- States:
  - IDLE: if `start`, go to LOAD. Clear `row_cnt`, `col_cnt`, `pair_cnt`, `beat_cnt` and the half flag.
  - LOAD: accept pairs.
    - Even r: the pair goes to the half register.
    - Odd r: the beat {half_a, in_a, half_b, in_b} is pushed into the FIFO.
    - `row_cnt` steps by 1. On wrap at MATRIX_WIDTH-1 it returns to 0 and `col_cnt` increments.
    - The PAIRS-th acceptance moves the FSM to DRAIN.
  - DRAIN: no input accepted. When the final beat is emitted (`read_en` with `beat_cnt` == BEATS-1), go to IDLE.
- `in_ready` = (state == LOAD) && (fifo_count < 2). It is derived from registers only. A push therefore always has space.
- Pop: when fifo_count > 0 and `sink_ready`, pop the head.
- `rdata` and `read_en` are registered, loaded at the pop edge:
  - `read_en` = 1 for exactly one cycle per popped beat.
  - `rdata` holds its last value otherwise.
- Push and pop on the same edge: count unchanged, order preserved.
- `start` in LOAD or DRAIN is ignored. `start` on the cycle of the IDLE return is not seen; it must be sampled in IDLE.
- Reset at any point:
  - state → IDLE; FIFO, counters and half register cleared.
  - `rdata`=0, `read_en`=0, `load_done`=0, `in_ready`=0, `busy`=0.
  - A partial matrix is discarded; no beat is emitted after reset.

## Timing
- Reset values: all outputs 0.
- Latency, `sink_ready` held high: second pair of a beat accepted in cycle n → beat in FIFO in n+1 → `read_en` high in n+2.
- Throughput: 1 pair/cycle in, 1 beat per 2 cycles out. The FIFO never fills when `sink_ready` is high.
- Backpressure: with `sink_ready` low, `in_ready` drops in the cycle after the 2nd beat is pushed. At most 1 pair waits in the half register.
- `load_done` is high in the same cycle as the BEATS-th `read_en`. `busy` falls the following cycle.
- IDLE → LOAD: `in_ready` can be high in the cycle after `start` is sampled.

## Structure
- Package `matrix_loader_pkg`:
  - state enum (IDLE, LOAD, DRAIN);
  - PAIRS and BEATS derivation;
  - beat pack function.
- Sub-module `beat_fifo`: 2-entry synchronous FIFO, NUM_ELEMENTS*WIDTH wide, with push/pop/count, synchronous reset.
- Top level: FSM, counters, half register, output registers.

## Test plan
- Reset: hold `reset` for 3 cycles with `in_valid`=1 → all outputs 0, no acceptance.
- Full load, `sink_ready`=1, A[r][c]=4r+c, B[r][c]=0x80+4r+c → 8 `read_en` pulses.
  - Beat 0 = 0x00048084, beat 1 = 0x080C888C, beat 2 = 0x01058185, beat 7 = 0x0B0F8B8F.
  - `load_done` with beat 7; `busy` low next cycle.
- Backpressure, `sink_ready`=0 from start → `in_ready` falls after 4 pairs (FIFO=2).
  - Raise `sink_ready` → beats emerge in order and the load completes with no loss or duplication.
- Random `in_valid` gaps and toggling `sink_ready` → output sequence identical to the full-load scenario; exactly 8 strobes.
- `start` pulsed in LOAD and DRAIN → ignored; a single `load_done`.
- `reset` after 5 pairs, then a new `start` and a full load → no stale beat; the first beat equals the new beat 0.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// Shared types and helpers for the matrix stream loader: FSM states,
// pair/beat count derivation and the engine load-format beat packer.
package matrix_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  // Widest element the packer handles; the top truncates to its own beat width.
  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0]   elem_t;
  typedef logic [4*MAX_W-1:0] wide_beat_t;

  function automatic int pairs_of(input int mw);
    return mw * mw;
  endfunction

  function automatic int beats_of(input int mw);
    return (mw * mw) / 2;
  endfunction

  // {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}, each field w bits wide.
  function automatic wide_beat_t pack_beat(input elem_t a_hi, input elem_t a_lo,
                                           input elem_t b_hi, input elem_t b_lo,
                                           input int w);
    wide_beat_t beat;
    beat = wide_beat_t'(b_lo);
    beat = beat | (wide_beat_t'(b_hi) << w);
    beat = beat | (wide_beat_t'(a_lo) << (2 * w));
    beat = beat | (wide_beat_t'(a_hi) << (3 * w));
    return beat;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Two-entry synchronous FIFO holding packed beats between the packer and the engine.
module beat_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Packs column-major (A, B) element pairs into two-row engine load beats,
// buffers them in a 2-entry FIFO and flags the end of a matrix load.
module matrix_stream_loader
  import matrix_loader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  output logic                          in_ready,
  input  logic                          sink_ready,
  output logic [NUM_ELEMENTS*WIDTH-1:0] rdata,
  output logic                          read_en,
  output logic                          busy,
  output logic                          load_done
);

  localparam int BEAT_W = NUM_ELEMENTS * WIDTH;
  localparam int PAIRS  = pairs_of(MATRIX_WIDTH);
  localparam int BEATS  = beats_of(MATRIX_WIDTH);
  localparam int RW     = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int PW     = $clog2(PAIRS + 1);
  localparam int BW     = $clog2(BEATS + 1);

  if (NUM_ELEMENTS != 4) begin : g_bad_num_elements
    $error("matrix_stream_loader: NUM_ELEMENTS must be 4");
  end
  if ((MATRIX_WIDTH % 2) != 0 || MATRIX_WIDTH < 2) begin : g_bad_matrix_width
    $error("matrix_stream_loader: MATRIX_WIDTH must be even");
  end
  if (WIDTH > MAX_W || WIDTH < 1) begin : g_bad_width
    $error("matrix_stream_loader: WIDTH out of range");
  end

  state_t            state;
  logic [RW-1:0]     row_cnt;
  logic [RW-1:0]     col_cnt;
  logic [PW-1:0]     pair_cnt;
  logic [BW-1:0]     beat_cnt;
  logic              half_full;
  logic [WIDTH-1:0]  half_a;
  logic [WIDTH-1:0]  half_b;
  logic [BEAT_W-1:0] push_beat;
  logic [BEAT_W-1:0] head;
  logic [1:0]        fifo_count;
  logic              accept;
  logic              push;
  logic              pop;

  // Ready depends only on registered state, so a push always finds space.
  assign in_ready  = (state == LOAD) && (fifo_count < 2'd2);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign push      = accept && half_full;
  assign pop       = (fifo_count != 2'd0) && sink_ready;
  assign push_beat = BEAT_W'(pack_beat(elem_t'(half_a), elem_t'(in_a),
                                       elem_t'(half_b), elem_t'(in_b), WIDTH));

  beat_fifo #(
    .W(BEAT_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(push_beat),
    .head (head),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      col_cnt   <= '0;
      pair_cnt  <= '0;
      beat_cnt  <= '0;
      half_full <= 1'b0;
      half_a    <= '0;
      half_b    <= '0;
      rdata     <= '0;
      read_en   <= 1'b0;
      load_done <= 1'b0;
    end else begin
      read_en   <= pop;
      load_done <= pop && (beat_cnt == BW'(BEATS - 1));
      if (pop) begin
        rdata    <= head;
        beat_cnt <= beat_cnt + BW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            row_cnt   <= '0;
            col_cnt   <= '0;
            pair_cnt  <= '0;
            beat_cnt  <= '0;
            half_full <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            // Even rows park in the half register; odd rows complete a beat.
            if (!half_full) begin
              half_a <= in_a;
              half_b <= in_b;
            end
            half_full <= ~half_full;
            if (row_cnt == RW'(MATRIX_WIDTH - 1)) begin
              row_cnt <= '0;
              col_cnt <= col_cnt + RW'(1);
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
            pair_cnt <= pair_cnt + PW'(1);
            if (pair_cnt == PW'(PAIRS - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // load_done marks the final read_en; leave one cycle later.
          if (load_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: expected beats queued at pair
// acceptance and compared when read_en strobes.
module tb_matrix_stream_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        sink_ready;
  logic [31:0] rdata;
  logic        read_en;
  logic        busy;
  logic        load_done;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] got[$];
  logic [31:0] ref_beats[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          p;
  int          beat_idx;
  int          base_v;
  int          strobes;
  int          dones;
  bit          done_flag;
  bit          prev_done = 1'b0;
  logic [7:0]  ha;
  logic [7:0]  hb;

  matrix_stream_loader #(
    .WIDTH       (8),
    .NUM_ELEMENTS(4),
    .MATRIX_WIDTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .sink_ready(sink_ready),
    .rdata     (rdata),
    .read_en   (read_en),
    .busy      (busy),
    .load_done (load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] elem_a(input int idx);
    int r;
    int c;
    r = idx % 4;
    c = idx / 4;
    return 8'(4 * r + c + base_v);
  endfunction

  function automatic logic [7:0] elem_b(input int idx);
    int r;
    int c;
    r = idx % 4;
    c = idx / 4;
    return 8'(8'h80 + 4 * r + c + base_v);
  endfunction

  // Reference packing: even row parked, odd row completes {Ahi, Alo, Bhi, Blo}.
  task automatic model_accept();
    exp_t e;
    if ((p % 4) % 2 == 0) begin
      ha = elem_a(p);
      hb = elem_b(p);
    end else begin
      e.data = {ha, elem_a(p), hb, elem_b(p)};
      e.last = (beat_idx == 7);
      sb.push_back(e);
      beat_idx++;
    end
    p++;
  endtask

  // Advance one cycle; acceptance is judged just before the edge.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready && !reset) model_accept();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (prev_done) check("busy_fall_after_done", 64'(busy), 64'(0));
    prev_done = load_done;
    if (read_en) begin
      check("beat_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("beat_data", 64'(rdata), 64'(mon_e.data));
        check("load_done_on_last", 64'(load_done), 64'(mon_e.last));
      end
      got.push_back(rdata);
      strobes++;
    end else begin
      check("done_without_strobe", 64'(load_done), 64'(0));
    end
    if (load_done) begin
      dones++;
      done_flag = 1'b1;
    end
  end

  task automatic check_outputs_zero();
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_read_en", 64'(read_en), 64'(0));
    check("rst_load_done", 64'(load_done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic begin_load(input int base);
    strobes   = 0;
    dones     = 0;
    done_flag = 1'b0;
    got.delete();
    p        = 0;
    beat_idx = 0;
    base_v   = base;
    start    = 1'b1;
    step();
    start    = 1'b0;
    check("in_ready_after_start", 64'(in_ready), 64'(1));
  endtask

  task automatic feed(input int stop_p, input int gap_pct, input int sink_pct,
                      input int start_pct, input int max_cyc);
    int cyc;
    cyc = 0;
    while (p < stop_p && cyc < max_cyc) begin
      in_valid   = ($urandom_range(99) >= gap_pct);
      in_a       = elem_a(p);
      in_b       = elem_b(p);
      sink_ready = ($urandom_range(99) < sink_pct);
      start      = ($urandom_range(99) < start_pct);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("feed_pairs_accepted", 64'(p), 64'(stop_p));
  endtask

  task automatic wait_drain(input int max_cyc);
    int cyc;
    cyc        = 0;
    sink_ready = 1'b1;
    while ((sb.size() != 0 || !done_flag) && cyc < max_cyc) begin
      step();
      cyc++;
    end
    check("drain_complete", 64'(done_flag && sb.size() == 0), 64'(1));
    step();
    step();
    check("busy_after_load", 64'(busy), 64'(0));
    check("strobe_count", 64'(strobes), 64'(8));
    check("done_count", 64'(dones), 64'(1));
  endtask

  task automatic compare_to_ref(input string tag);
    for (int i = 0; i < 8; i++) begin
      check(tag, (i < got.size()) ? 64'(got[i]) : 64'hFFFF_FFFF_FFFF_FFFF,
            (i < ref_beats.size()) ? 64'(ref_beats[i]) : 64'h0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b1;
    in_a       = 8'h11;
    in_b       = 8'h22;
    sink_ready = 1'b1;
    p          = 0;
    beat_idx   = 0;
    base_v     = 0;
    strobes    = 0;
    dones      = 0;
    done_flag  = 1'b0;
    ha         = 8'h0;
    hb         = 8'h0;

    // Reset held with in_valid high: all outputs zero, nothing accepted.
    for (int i = 0; i < 3; i++) begin
      step();
      check_outputs_zero();
    end
    check("rst_no_accept", 64'(p), 64'(0));
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("idle_busy", 64'(busy), 64'(0));

    // Full load with the engine always ready.
    begin_load(0);
    feed(16, 0, 100, 0, 100);
    wait_drain(50);
    check("beat0_const", (got.size() > 0) ? 64'(got[0]) : 64'hFFFF, 64'h0004_8084);
    check("beat1_const", (got.size() > 1) ? 64'(got[1]) : 64'hFFFF, 64'h080C_888C);
    check("beat2_const", (got.size() > 2) ? 64'(got[2]) : 64'hFFFF, 64'h0105_8185);
    check("beat7_const", (got.size() > 7) ? 64'(got[7]) : 64'hFFFF, 64'h0B0F_8B8F);
    ref_beats = got;

    // Backpressure from the start: two beats fill the FIFO, then ready drops.
    sink_ready = 1'b0;
    begin_load(0);
    feed(4, 0, 0, 0, 20);
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    in_a     = elem_a(p);
    in_b     = elem_b(p);
    for (int i = 0; i < 5; i++) step();
    check("bp_stall_pairs", 64'(p), 64'(4));
    check("bp_no_strobe", 64'(strobes), 64'(0));
    feed(16, 0, 100, 0, 100);
    wait_drain(50);
    compare_to_ref("bp_sequence");

    // Random input gaps and toggling sink_ready.
    begin_load(0);
    feed(16, 30, 50, 0, 400);
    wait_drain(100);
    compare_to_ref("random_sequence");

    // start pulses during LOAD and DRAIN are ignored.
    begin_load(0);
    feed(16, 0, 100, 40, 100);
    check("busy_in_drain", 64'(busy), 64'(1));
    start = 1'b1;
    step();
    start = 1'b0;
    wait_drain(50);
    for (int i = 0; i < 3; i++) step();
    check("start_ignored_idle", 64'(busy), 64'(0));
    compare_to_ref("start_pulse_sequence");

    // Reset mid-load, then a fresh load with different data.
    begin_load(0);
    feed(5, 0, 100, 0, 40);
    reset = 1'b1;
    step();
    sb.delete();
    p        = 0;
    beat_idx = 0;
    check_outputs_zero();
    step();
    reset = 1'b0;
    step();
    check("post_reset_idle", 64'(busy), 64'(0));
    begin_load(16);
    feed(16, 0, 100, 0, 100);
    wait_drain(50);
    check("post_reset_beat0", (got.size() > 0) ? 64'(got[0]) : 64'hFFFF, 64'h1014_9094);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
